// File: rtl/la_fork3_if.sv
// la_fork3_if: valid/ready bundle for the three-way eager fork.
// One input stream (in_*) and three output channels sharing one payload
// (out_*). Channel bit ordering everywhere: bit0 = a, bit1 = b, bit2 = c.
interface la_fork3_if #(
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [2:0]    in_mask;
    logic [2:0]    out_valid;
    logic [2:0]    out_ready;
    logic [DW-1:0] out_data;

    // Producer of input tokens and consumer of the three output channels
    modport master (
        output in_valid,
        output in_data,
        output in_mask,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    // The fork itself
    modport slave (
        input  in_valid,
        input  in_data,
        input  in_mask,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/la_fork_ch.sv
// la_fork_ch: one output channel of the fork. Holds the pending flag for
// its channel and reports whether it will still be pending after this
// cycle's handshake, which the top ANDs into the input ready.
module la_fork_ch (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic set,
    input  logic ready,
    output logic valid,
    output logic remaining
);
    logic r_pending;

    assign valid     = r_pending;
    assign remaining = r_pending & ~ready;

    // Pending flag: cleared by reset, reloaded on a new token, else drops on handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 1'b0;
        end else if (load) begin
            r_pending <= set;
        end else begin
            r_pending <= remaining;
        end
    end
endmodule

// File: rtl/la_fork3.sv
// la_fork3: registered eager fork. One valid/ready input token is
// broadcast to channels a/b/c (bit0/bit1/bit2), each completing its own
// handshake. A new token is taken only once every targeted channel has
// taken the current one; in_ready depends combinationally on out_ready
// so a last completion and a new accept can share a cycle.
// A zero in_mask accepts and drops the token without touching the payload.
// PROP is the cell-library implementation property and is passed through.
module la_fork3 #(
    parameter string PROP = "DEFAULT",
    parameter int    DW   = 32
) (
    input  logic            clk,
    input  logic            rst,
    la_fork3_if.slave       bus
);
    logic [DW-1:0] r_data;
    logic [2:0]    w_remaining;
    logic [2:0]    w_valid;
    logic          w_inReady;
    logic          w_accept;

    assign w_inReady    = ~rst & (w_remaining == 3'b000);
    assign w_accept     = bus.in_valid & w_inReady;
    assign bus.in_ready = w_inReady;
    assign bus.out_valid = w_valid;
    assign bus.out_data  = r_data;

    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
        la_fork_ch u_ch (
            .clk       (clk),
            .rst       (rst),
            .load      (w_accept),
            .set       (bus.in_mask[gi]),
            .ready     (bus.out_ready[gi]),
            .valid     (w_valid[gi]),
            .remaining (w_remaining[gi])
        );
    end

    // Payload register: captured only for tokens that go somewhere
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else if (w_accept && (bus.in_mask != 3'b000)) begin
            r_data <= bus.in_data;
        end
    end
endmodule

// File: tb/tb_la_fork3.sv
// tb_la_fork3: directed bench for la_fork3. Stimulus pushes the payload
// expected on each targeted channel into a per-channel queue when the
// token is accepted; a negedge monitor pops and compares on every output
// handshake and flags any valid with nothing outstanding.
module tb_la_fork3;
    localparam int DW = 32;

    logic clk;
    logic rst;
    int   checkCount;
    int   errorCount;
    logic [DW-1:0] expQ[3][$];

    la_fork3_if #(.DW(DW)) bus ();

    la_fork3 #(.PROP("DEFAULT"), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence never reaches its end
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compare the payload on every completed output handshake
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) expQ[i].delete();
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (bus.out_valid[i] === 1'b1) begin
                    checkCount++;
                    if (expQ[i].size() == 0) begin
                        errorCount++;
                        $display("[TB] FAIL ch%0d_unexpected actual=valid data=%h required=idle", i, bus.out_data);
                    end else if (bus.out_ready[i] === 1'b1) begin
                        logic [DW-1:0] e;
                        e = expQ[i].pop_front();
                        if (bus.out_data !== e) begin
                            errorCount++;
                            $display("[TB] FAIL ch%0d_data actual=%h required=%h", i, bus.out_data, e);
                        end
                    end
                end
            end
        end
    end

    // One cycle: drive inputs, check ready/valid at negedge, record accepted token
    task automatic applyStimulus(input logic vin, input logic [DW-1:0] d, input logic [2:0] m,
                                 input logic [2:0] ordy, input logic expRdy, input logic [2:0] expVld,
                                 input string tag);
        bus.in_valid  = vin;
        bus.in_data   = d;
        bus.in_mask   = m;
        bus.out_ready = ordy;
        @(negedge clk);
        checkOutput({tag, "_in_ready"}, DW'(bus.in_ready), DW'(expRdy));
        checkOutput({tag, "_out_valid"}, DW'(bus.out_valid), DW'(expVld));
        if (vin && bus.in_ready === 1'b1) begin
            for (int i = 0; i < 3; i++) if (m[i]) expQ[i].push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [DW-1:0] XD = 'x;

    initial begin
        checkCount    = 0;
        errorCount    = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hDEAD;
        bus.in_mask   = 3'b111;
        bus.out_ready = 3'b111;

        // Reset held two cycles with a token offered
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checkOutput("rst_in_ready", DW'(bus.in_ready), '0);
            checkOutput("rst_out_valid", DW'(bus.out_valid), '0);
            checkOutput("rst_out_data", bus.out_data, '0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        applyStimulus(1'b0, XD, 3'bxxx, 3'b000, 1'b1, 3'b000, "rel");

        // Full throughput stream
        applyStimulus(1'b1, 32'h11, 3'b111, 3'b111, 1'b1, 3'b000, "thr0");
        applyStimulus(1'b1, 32'h22, 3'b111, 3'b111, 1'b1, 3'b111, "thr1");
        applyStimulus(1'b1, 32'h33, 3'b111, 3'b111, 1'b1, 3'b111, "thr2");
        applyStimulus(1'b0, XD, 3'bxxx, 3'b111, 1'b1, 3'b111, "thr3");
        applyStimulus(1'b0, XD, 3'bxxx, 3'b000, 1'b1, 3'b000, "thr4");

        // Staggered completion a, c, b with the next token waiting
        applyStimulus(1'b1, 32'hA5, 3'b111, 3'b000, 1'b1, 3'b000, "stg0");
        applyStimulus(1'b1, 32'h5A, 3'b111, 3'b001, 1'b0, 3'b111, "stg1");
        applyStimulus(1'b1, 32'h5A, 3'b111, 3'b000, 1'b0, 3'b110, "stg2");
        applyStimulus(1'b1, 32'h5A, 3'b111, 3'b100, 1'b0, 3'b110, "stg3");
        applyStimulus(1'b1, 32'h5A, 3'b111, 3'b000, 1'b0, 3'b010, "stg4");
        applyStimulus(1'b1, 32'h5A, 3'b111, 3'b010, 1'b1, 3'b010, "stg5");
        applyStimulus(1'b0, XD, 3'bxxx, 3'b111, 1'b1, 3'b111, "stg6");
        applyStimulus(1'b0, XD, 3'bxxx, 3'b000, 1'b1, 3'b000, "stg7");

        // Partial mask a+c held while only b is ready
        applyStimulus(1'b1, 32'h0F, 3'b101, 3'b010, 1'b1, 3'b000, "pm0");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, XD, 3'bxxx, 3'b010, 1'b0, 3'b101, "pmHold");
            checkOutput("pm_data_stable", bus.out_data, 32'h0F);
        end
        applyStimulus(1'b0, XD, 3'bxxx, 3'b101, 1'b1, 3'b101, "pmRel");
        applyStimulus(1'b0, XD, 3'bxxx, 3'b000, 1'b1, 3'b000, "pmIdle");

        // Zero mask drops the token and keeps the old payload
        applyStimulus(1'b1, 32'hFF, 3'b000, 3'b000, 1'b1, 3'b000, "zm0");
        checkOutput("zm_data_kept", bus.out_data, 32'h0F);
        applyStimulus(1'b1, 32'h01, 3'b001, 3'b000, 1'b1, 3'b000, "zm1");
        applyStimulus(1'b0, XD, 3'bxxx, 3'b001, 1'b1, 3'b001, "zm2");
        applyStimulus(1'b0, XD, 3'bxxx, 3'b000, 1'b1, 3'b000, "zm3");

        // Reset while b and c are still pending
        applyStimulus(1'b1, 32'h77, 3'b111, 3'b001, 1'b1, 3'b000, "rm0");
        applyStimulus(1'b0, XD, 3'bxxx, 3'b001, 1'b0, 3'b111, "rm1");
        rst = 1'b1;
        applyStimulus(1'b0, XD, 3'bxxx, 3'b110, 1'b0, 3'b110, "rmRst");
        rst = 1'b0;
        applyStimulus(1'b0, XD, 3'bxxx, 3'b000, 1'b1, 3'b000, "rmAfter");
        checkOutput("rm_data_cleared", bus.out_data, '0);
        applyStimulus(1'b1, 32'h99, 3'b010, 3'b010, 1'b1, 3'b000, "rmNew0");
        applyStimulus(1'b0, XD, 3'bxxx, 3'b010, 1'b1, 3'b010, "rmNew1");
        applyStimulus(1'b0, XD, 3'bxxx, 3'b000, 1'b1, 3'b000, "rmNew2");

        // Every recorded token must have been delivered
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("ch%0d_drained", i), DW'(expQ[i].size()), '0);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end
endmodule
